spi_shift_engine: RTL and testbench
===================================

Name: spi_shift_engine

Overview:
- Data shift stage sitting directly downstream of the SPI clock generator.
- Consumes the generator's pos_edge/neg_edge pulses to drive MOSI and sample MISO, one bit per SCLK edge.
- Supports configurable character length and bit order.
- Produces the generator's enable (tip_o) and last_clk (last_bit_o) controls, plus the received word and a done pulse for the register interface.

Parameters:
- DATA_W, 32, maximum character length in bits; rx/tx data width.
- LEN_W, $clog2(DATA_W), width of char_len_i.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- go_i  in  1  start pulse; accepted only in IDLE
- char_len_i  in  LEN_W  bits per transfer; 0 means DATA_W
- lsb_first_i  in  1  1 = bit 0 first, 0 = bit len-1 first
- tx_negedge_i  in  1  1 = drive MOSI on neg_edge_i, 0 = on pos_edge_i
- rx_negedge_i  in  1  1 = sample MISO on neg_edge_i, 0 = on pos_edge_i
- pos_edge_i  in  1  SCLK rising-edge strobe from clock generator
- neg_edge_i  in  1  SCLK falling-edge strobe from clock generator
- tx_data_i  in  DATA_W  word to transmit, latched on accepted go_i
- miso_i  in  1  serial input
- mosi_o  out  1  serial output
- tip_o  out  1  transfer in progress; drives clock generator enable
- last_bit_o  out  1  final bit period; drives clock generator last_clk
- done_o  out  1  one-cycle pulse, rx_data_o valid
- rx_data_o  out  DATA_W  received word

Behaviour:
- Reset values: mosi_o=0, tip_o=0, last_bit_o=0, done_o=0, rx_data_o=0. Internal state is IDLE, counters are 0, shift registers are 0.
- FSM states: IDLE, XFER, DONE.
  - IDLE→XFER on go_i: latch tx_data_i, latch len (char_len_i, with 0 mapped to DATA_W), latch the order and edge selects. Set tx_rem=len and rx_rem=len (LEN_W+1 bits). Clear the rx shift register. tip_o goes to 1 the next cycle.
  - XFER→DONE in the cycle after the rx edge that makes rx_rem reach 0.
  - DONE→IDLE unconditionally after 1 cycle. done_o=1 only in DONE; rx_data_o updates on entry to DONE.
- tx_edge = tx_negedge ? neg_edge_i : pos_edge_i. rx_edge is the same using rx_negedge.
- On tx_edge in XFER with tx_rem>0, mosi_o is driven with the next bit:
  - MSB-first: index tx_rem-1.
  - LSB-first: index len-tx_rem.
  - tx_rem then decrements. A tx_edge with tx_rem=0 leaves mosi_o unchanged.
- On rx_edge in XFER with rx_rem>0, miso_i is written into the rx register at the same index formula using rx_rem; rx_rem then decrements.
- rx_data_o bits at index ≥ len are 0.
- tx_edge and rx_edge in the same cycle: both actions occur.
- Edge strobes outside XFER are ignored.
- go_i while in XFER or DONE is ignored; latched config and data are unaffected.
- Config inputs changing mid-transfer have no effect, since the latched copies are used.
- tip_o=1 exactly in XFER. last_bit_o = (state==XFER) && (rx_rem==1), combinationally decoded from registered state.
- Latency: go_i→tip_o is 1 cycle. Final rx_edge→done_o is 1 cycle.
- Reset mid-transfer returns immediately to reset values; no done_o is produced.

Optional Feature:
- Macro: SPI_LOOPBACK_EN.
- Defined: adds input port loopback_i (1 bit). When it is 1, the rx path samples the internal mosi_o register instead of miso_i. The selection is sampled each rx_edge.
- Undefined: no loopback_i port; rx always samples miso_i.

Decomposition:
- Shared package spi_pkg holds:
  - state enum spi_shift_state_e (IDLE, XFER, DONE)
  - default DATA_W
  - the rule mapping length 0 to DATA_W, as a function or constant
- One natural sub-module: spi_bit_index. Inputs are len, rem and lsb_first; output is the bit index. It is instantiated twice, once for tx and once for rx.

Test Plan:
- Reset with rst_ni=0 mid-XFER after 3 bits → all outputs 0 immediately; no done_o; the next go_i starts cleanly.
- len=8, MSB-first, tx_data=0xA5, tx on neg, rx on pos, miso looped to mosi externally, clock generator divider=1 → mosi sequence 1,0,1,0,0,1,0,1. rx_data_o=0x000000A5. done_o is one cycle. last_bit_o is high only during the 8th bit.
- len=0 (32 bits), LSB-first, tx_data=0x80000001 → first mosi bit 1, bits 2..31 are 0, last bit 1. 32 rx samples; tip_o falls 1 cycle after the 32nd rx_edge.
- go_i pulsed again at cycle 5 of an 8-bit transfer with different tx_data → ignored; the original word completes unchanged.
- Divider=0 with pos/neg edges every cycle, len=4, tx_data=0x9 → transfer completes in about 8 edge cycles. rx_data_o=0x9 with external loopback. Bits 4..31 of rx_data_o are 0.
- SPI_LOOPBACK_EN defined, loopback_i=1, miso_i tied 0, len=16, tx_data=0xBEEF → rx_data_o=0x0000BEEF. With loopback_i=0 → rx_data_o=0.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI shift engine.
// Holds the FSM state encoding and the character-length mapping rule.
package spi_pkg;

    localparam int unsigned SPI_DATA_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } spi_shift_state_e;

    // A programmed length of 0 means a full-width character; oversize values clamp to full width.
    function automatic int unsigned spi_eff_len(input int unsigned char_len,
                                                input int unsigned data_w);
        return (char_len == 0 || char_len > data_w) ? data_w : char_len;
    endfunction

endpackage

// File: rtl/spi_bit_index.sv
// Maps a remaining-bit count to a data bit position for MSB- or LSB-first order.
// Combinational; modulo-2^LEN_W arithmetic is exact because the result is always below len.
module spi_bit_index #(
    parameter int unsigned LEN_W = 5
) (
    input  logic [LEN_W-1:0] len,
    input  logic [LEN_W-1:0] rem,
    input  logic             lsb_first,
    output logic [LEN_W-1:0] idx
);

    assign idx = lsb_first ? (len - rem) : (rem - LEN_W'(1));

endmodule

// File: rtl/spi_shift_engine.sv
// SPI data shifter driven by clock-generator edge strobes; SPI_LOOPBACK_EN adds loopback_i (rx samples mosi_o).
// Latency: go_i -> tip_o 1 cycle; final rx edge -> done_o (and rx_data_o) 1 cycle.
// Backpressure: none; strobes are consumed as they arrive and go_i is ignored unless IDLE.
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W = SPI_DATA_W_DEFAULT,
    parameter int unsigned LEN_W  = $clog2(DATA_W)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              go_i,
    input  logic [LEN_W-1:0]  char_len_i,
    input  logic              lsb_first_i,
    input  logic              tx_negedge_i,
    input  logic              rx_negedge_i,
    input  logic              pos_edge_i,
    input  logic              neg_edge_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              miso_i,
`ifdef SPI_LOOPBACK_EN
    input  logic              loopback_i,
`endif
    output logic              mosi_o,
    output logic              tip_o,
    output logic              last_bit_o,
    output logic              done_o,
    output logic [DATA_W-1:0] rx_data_o
);

    localparam int unsigned CW = LEN_W + 1;

    spi_shift_state_e  state;
    logic [CW-1:0]     len_in;
    logic [CW-1:0]     tx_rem;
    logic [CW-1:0]     rx_rem;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  tx_idx;
    logic [LEN_W-1:0]  rx_idx;
    logic              lsb_q;
    logic              tx_neg_q;
    logic              rx_neg_q;
    logic [DATA_W-1:0] tx_q;
    logic [DATA_W-1:0] rx_shift;
    logic [DATA_W-1:0] rx_next;
    logic              tx_fire;
    logic              rx_fire;
    logic              rx_bit;

    assign len_in = CW'(spi_eff_len(32'(char_len_i), DATA_W));

    assign tx_fire = (state == XFER) && (tx_neg_q ? neg_edge_i : pos_edge_i) && (tx_rem != '0);
    assign rx_fire = (state == XFER) && (rx_neg_q ? neg_edge_i : pos_edge_i) && (rx_rem != '0);

`ifdef SPI_LOOPBACK_EN
    assign rx_bit = loopback_i ? mosi_o : miso_i;
`else
    assign rx_bit = miso_i;
`endif

    // Only the low LEN_W bits of len/rem matter: a full-width length wraps to 0 harmlessly.
    spi_bit_index #(.LEN_W(LEN_W)) u_tx_index (
        .len       (len_q),
        .rem       (tx_rem[LEN_W-1:0]),
        .lsb_first (lsb_q),
        .idx       (tx_idx)
    );

    spi_bit_index #(.LEN_W(LEN_W)) u_rx_index (
        .len       (len_q),
        .rem       (rx_rem[LEN_W-1:0]),
        .lsb_first (lsb_q),
        .idx       (rx_idx)
    );

    always_comb begin
        rx_next = rx_shift;
        rx_next[rx_idx] = rx_bit;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            mosi_o    <= 1'b0;
            rx_data_o <= '0;
            tx_rem    <= '0;
            rx_rem    <= '0;
            len_q     <= '0;
            lsb_q     <= 1'b0;
            tx_neg_q  <= 1'b0;
            rx_neg_q  <= 1'b0;
            tx_q      <= '0;
            rx_shift  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (go_i) begin
                        state    <= XFER;
                        tx_q     <= tx_data_i;
                        len_q    <= len_in[LEN_W-1:0];
                        tx_rem   <= len_in;
                        rx_rem   <= len_in;
                        lsb_q    <= lsb_first_i;
                        tx_neg_q <= tx_negedge_i;
                        rx_neg_q <= rx_negedge_i;
                        rx_shift <= '0;
                    end
                end
                XFER: begin
                    if (tx_fire) begin
                        mosi_o <= tx_q[tx_idx];
                        tx_rem <= tx_rem - CW'(1);
                    end
                    if (rx_fire) begin
                        rx_shift <= rx_next;
                        rx_rem   <= rx_rem - CW'(1);
                        // Publish the word with the final bit merged in as DONE is entered.
                        if (rx_rem == CW'(1)) begin
                            state     <= DONE;
                            rx_data_o <= rx_next;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign tip_o      = (state == XFER);
    assign done_o     = (state == DONE);
    assign last_bit_o = (state == XFER) && (rx_rem == CW'(1));

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed and randomized bench for spi_shift_engine with a behavioural clock-generator and slave model.
module tb_spi_shift_engine;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        go_i = 1'b0;
    logic [4:0]  char_len_i = '0;
    logic        lsb_first_i = 1'b0;
    logic        tx_negedge_i = 1'b0;
    logic        rx_negedge_i = 1'b0;
    logic        pos_edge_i = 1'b0;
    logic        neg_edge_i = 1'b0;
    logic [31:0] tx_data_i = '0;
    logic        miso_i;
    logic        miso_drv = 1'b0;
    logic        ext_lb = 1'b0;
`ifdef SPI_LOOPBACK_EN
    logic        loopback_i = 1'b0;
`endif
    logic        mosi_o;
    logic        tip_o;
    logic        last_bit_o;
    logic        done_o;
    logic [31:0] rx_data_o;

    int total = 0;
    int bad = 0;

    assign miso_i = ext_lb ? mosi_o : miso_drv;

    always #5 clk_i = ~clk_i;

    spi_shift_engine dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .go_i         (go_i),
        .char_len_i   (char_len_i),
        .lsb_first_i  (lsb_first_i),
        .tx_negedge_i (tx_negedge_i),
        .rx_negedge_i (rx_negedge_i),
        .pos_edge_i   (pos_edge_i),
        .neg_edge_i   (neg_edge_i),
        .tx_data_i    (tx_data_i),
        .miso_i       (miso_i),
`ifdef SPI_LOOPBACK_EN
        .loopback_i   (loopback_i),
`endif
        .mosi_o       (mosi_o),
        .tip_o        (tip_o),
        .last_bit_o   (last_bit_o),
        .done_o       (done_o),
        .rx_data_o    (rx_data_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Position of the k-th bit on the wire.
    function automatic int ord(input int k, input int len, input bit lsb);
        return lsb ? k : (len - 1 - k);
    endfunction

    function automatic logic [31:0] lmask(input int len);
        return (len >= 32) ? 32'hFFFF_FFFF : ((32'd1 << len) - 32'd1);
    endfunction

    // One transfer: the bench acts as clock generator (tx-type edge first, then alternating,
    // one strobe every div+1 cycles) and as a slave shifting out word 'slave' in the same order.
    task automatic run_xfer(input logic [31:0] data, input int clen, input bit lsb,
                            input bit txn, input bit rxn, input int div,
                            input bit lb_ext, input bit lb_int, input logic [31:0] slave,
                            input int rego_at, input int abort_rx, input string name);
        int          len;
        int          rxk;
        int          txk;
        int          gap;
        int          cyc;
        int          lastb;
        bit          cur_neg;
        bit          is_tx;
        bit          is_rx;
        bit          done_at_final;
        logic [31:0] got_mosi;
        logic [31:0] exp_rx;
        len = (clen == 0) ? 32 : clen;
        rxk = 0; txk = 0; gap = 0; cyc = 0; lastb = 0;
        done_at_final = 0;
        got_mosi = '0;
        exp_rx = (lb_ext || lb_int) ? (data & lmask(len)) : (slave & lmask(len));
        ext_lb = lb_ext;
`ifdef SPI_LOOPBACK_EN
        loopback_i = lb_int;
`endif
        tx_data_i = data; char_len_i = 5'(clen); lsb_first_i = lsb;
        tx_negedge_i = txn; rx_negedge_i = rxn; go_i = 1'b1;
        @(negedge clk_i);
        go_i = 1'b0;
        chk($sformatf("%s tip_after_go", name), tip_o, 1);
        cur_neg = txn;
        while (tip_o && cyc < 3000) begin
            is_tx = 0; is_rx = 0;
            if (cyc == rego_at) begin
                go_i = 1'b1; tx_data_i = ~data; char_len_i = 5'd3;
                lsb_first_i = ~lsb; tx_negedge_i = ~txn;
            end
            if (gap == div) begin
                gap = 0;
                is_tx = (cur_neg == txn);
                is_rx = (cur_neg == rxn);
                if (cur_neg) neg_edge_i = 1'b1; else pos_edge_i = 1'b1;
                cur_neg = ~cur_neg;
                if (is_rx && rxk < len) begin
                    miso_drv = slave[ord(rxk, len, lsb)];
                    if (last_bit_o) lastb++;
                    rxk++;
                end else begin
                    is_rx = 0;
                end
            end else begin
                gap++;
            end
            @(negedge clk_i);
            pos_edge_i = 1'b0; neg_edge_i = 1'b0; go_i = 1'b0;
            cyc++;
            if (is_tx && txk < len) begin
                got_mosi[ord(txk, len, lsb)] = mosi_o;
                txk++;
            end
            if (abort_rx != 0 && rxk == abort_rx) begin
                rst_ni = 1'b0;
                #1;
                chk($sformatf("%s ctl_in_reset", name), {28'd0, mosi_o, tip_o, last_bit_o, done_o}, 0);
                chk($sformatf("%s rx_in_reset", name), rx_data_o, 0);
                repeat (2) @(negedge clk_i);
                chk($sformatf("%s no_done_after_reset", name), {done_o, tip_o}, 0);
                return;
            end
            if (is_rx && rxk == len) done_at_final = done_o && !tip_o;
        end
        chk($sformatf("%s finished_in_budget", name), (cyc < 3000), 1);
        chk($sformatf("%s rx_count", name), rxk, len);
        chk($sformatf("%s mosi_word", name), got_mosi, data & lmask(len));
        chk($sformatf("%s done_one_cycle_after_last_rx", name), done_at_final, 1);
        chk($sformatf("%s rx_data", name), rx_data_o, exp_rx);
        chk($sformatf("%s last_bit_only_on_final_rx", name), lastb, 1);
        chk($sformatf("%s last_bit_low_in_done", name), last_bit_o, 0);
        @(negedge clk_i);
        chk($sformatf("%s done_pulse_width", name), {done_o, tip_o}, 0);
        chk($sformatf("%s rx_data_held", name), rx_data_o, exp_rx);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] s;
        int          cl;
        int          dv;
        bit          l;
        bit          tn;
        bit          rn;
        bit          ex;

        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("reset_ctl", {28'd0, mosi_o, tip_o, last_bit_o, done_o}, 0);
        chk("reset_rx", rx_data_o, 0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        run_xfer(32'hFF, 8, 0, 1, 0, 1, 1, 0, 32'h0, -1, 3, "abort");
        rst_ni = 1'b1;
        @(negedge clk_i);

        run_xfer(32'hA5, 8, 0, 1, 0, 1, 1, 0, 32'h0, -1, 0, "a5_msb");
        run_xfer(32'h8000_0001, 0, 1, 1, 0, 1, 1, 0, 32'h0, -1, 0, "len32_lsb");
        run_xfer(32'h3C, 8, 0, 1, 0, 1, 1, 0, 32'h0, 5, 0, "go_ignored");
        run_xfer(32'hFFFF_FFF9, 4, 0, 1, 0, 0, 1, 0, 32'h0, -1, 0, "div0_len4");
        run_xfer(32'h1234_5678, 12, 1, 0, 0, 2, 0, 0, 32'hDEAD_B00F, -1, 0, "slave_same_edge");
`ifdef SPI_LOOPBACK_EN
        run_xfer(32'hBEEF, 16, 0, 1, 0, 1, 0, 1, 32'h0, -1, 0, "int_loopback_on");
        run_xfer(32'hBEEF, 16, 0, 1, 0, 1, 0, 0, 32'h0, -1, 0, "int_loopback_off");
`endif

        for (int i = 0; i < 24; i++) begin
            d  = $urandom;
            s  = $urandom;
            cl = $urandom_range(0, 31);
            dv = $urandom_range(0, 3);
            l  = 1'($urandom_range(0, 1));
            tn = 1'($urandom_range(0, 1));
            rn = 1'($urandom_range(0, 1));
            ex = (tn != rn) && ($urandom_range(0, 1) == 1);
            run_xfer(d, cl, l, tn, rn, dv, ex, 0, s, -1, 0, $sformatf("rand%0d", i));
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
